// File: rtl/sga_pkg.sv
// Shared constants and types for the snake body block: direction encoding,
// default geometry and the packed {x,y} position type.
package sga_pkg;

  localparam int unsigned GRID_BITS_DEF = 4;
  localparam int unsigned MAX_SIZE_DEF  = 16;
  localparam int unsigned INIT_SIZE_DEF = 3;
  localparam int unsigned START_X_DEF   = 8;
  localparam int unsigned START_Y_DEF   = 8;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // Position at the default grid size: x in the upper half, y in the lower half.
  typedef logic [2*GRID_BITS_DEF-1:0] pos_t;

endpackage

// File: rtl/sga_next_head.sv
// Combinational next-head step: (head, direction) -> (next head, border_hit).
// Build macro SGA_WRAP_EN makes coordinates wrap instead of reporting a border hit.
module sga_next_head
  import sga_pkg::*;
#(
  parameter int unsigned GRID_BITS = GRID_BITS_DEF
) (
  input  logic [2*GRID_BITS-1:0] head,
  input  logic [1:0]             direction,
  output logic [2*GRID_BITS-1:0] next_head,
  output logic                   border_hit
);

  localparam int unsigned GW = GRID_BITS;

  logic [GW-1:0] x;
  logic [GW-1:0] y;
  logic [GW:0]   x_sum;
  logic [GW:0]   y_sum;

  // One extra bit catches the carry out of x+1 / y+1 and the borrow out of x-1 / y-1.
  always_comb begin
    x     = head[2*GW-1:GW];
    y     = head[GW-1:0];
    x_sum = {1'b0, x};
    y_sum = {1'b0, y};
    case (direction)
      DIR_RIGHT: x_sum = {1'b0, x} + (GW+1)'(1);
      DIR_UP:    y_sum = {1'b0, y} - (GW+1)'(1);
      DIR_LEFT:  x_sum = {1'b0, x} - (GW+1)'(1);
      default:   y_sum = {1'b0, y} + (GW+1)'(1);
    endcase
`ifdef SGA_WRAP_EN
    border_hit = 1'b0;
`else
    border_hit = x_sum[GW] | y_sum[GW];
`endif
    next_head = {x_sum[GW-1:0], y_sum[GW-1:0]};
  end

endmodule

// File: rtl/sga_snake_body.sv
// Snake body store: segment array with load, shift-and-grow move and body-hit scan.
// Build macro SGA_WRAP_EN selects wrap-around movement at the grid edge.
module sga_snake_body
  import sga_pkg::*;
#(
  parameter int unsigned GRID_BITS = GRID_BITS_DEF,
  parameter int unsigned MAX_SIZE  = MAX_SIZE_DEF,
  parameter int unsigned INIT_SIZE = INIT_SIZE_DEF,
  parameter int unsigned START_X   = START_X_DEF,
  parameter int unsigned START_Y   = START_Y_DEF
) (
  input  logic                        clock,
  input  logic                        restart_n,
  input  logic                        clear_size,
  input  logic                        load_size,
  input  logic                        count_size,
  input  logic                        move,
  input  logic [1:0]                  direction,
  input  logic [2*GRID_BITS-1:0]      apple_pos,
  input  logic [$clog2(MAX_SIZE)-1:0] render_idx,
  output logic [2*GRID_BITS-1:0]      render_pos,
  output logic                        render_valid,
  output logic [2*GRID_BITS-1:0]      head_pos,
  output logic [$clog2(MAX_SIZE):0]   size,
  output logic                        busy,
  output logic                        done,
  output logic                        is_at_apple,
  output logic                        is_at_border,
  output logic                        is_at_body
);

  localparam int unsigned PW = 2*GRID_BITS;
  localparam int unsigned IW = $clog2(MAX_SIZE);
  localparam int unsigned SW = IW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HEAD  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [PW-1:0] seg [MAX_SIZE];
  logic [IW-1:0] idx;
  logic [SW-1:0] size_q;
  logic [SW-1:0] eff_q;
  logic [SW-1:0] size_eff;
  logic [PW-1:0] nh_q;
  logic [PW-1:0] next_head;
  logic          border_hit;
  logic          grow_q;
  logic          busy_q;
  logic          done_q;
  logic          border_q;
  logic          body_q;
  logic          start_clear;
  logic          start_load;
  logic          start_move;

  sga_next_head #(
    .GRID_BITS (GRID_BITS)
  ) u_next_head (
    .head       (seg[0]),
    .direction  (direction),
    .next_head  (next_head),
    .border_hit (border_hit)
  );

  // Effective length of the next move; a zero-length body still moves a single head cell.
  always_comb begin
    size_eff = size_q;
    if (grow_q && (size_q < SW'(MAX_SIZE))) size_eff = size_q + SW'(1);
    if (size_eff == '0) size_eff = SW'(1);
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_clear = 1'b0;
    start_load  = 1'b0;
    start_move  = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_size) begin
          start_clear = 1'b1;
        end else if (load_size) begin
          start_load = 1'b1;
          state_next = S_INIT;
        end else if (move) begin
          start_move = 1'b1;
          if (border_hit)                 state_next = S_DONE;
          else if (size_eff == SW'(1))    state_next = S_HEAD;
          else                            state_next = S_SHIFT;
        end
      end
      S_INIT:  if (idx == IW'(INIT_SIZE - 1)) state_next = S_DONE;
      S_SHIFT: if (idx == IW'(1)) state_next = S_HEAD;
      S_HEAD:  state_next = (eff_q == SW'(1)) ? S_DONE : S_CHECK;
      S_CHECK: if (SW'(idx) == (eff_q - SW'(1))) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Segment datapath: idx walks down during SHIFT and up during INIT/CHECK.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      for (int i = 0; i < MAX_SIZE; i++) seg[i] <= '0;
      idx      <= '0;
      size_q   <= '0;
      eff_q    <= '0;
      nh_q     <= '0;
      grow_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      border_q <= 1'b0;
      body_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != S_IDLE);
      done_q <= (state == S_DONE);
      if (count_size) grow_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_clear) size_q <= '0;
          if (start_load) begin
            idx      <= '0;
            border_q <= 1'b0;
            body_q   <= 1'b0;
          end
          if (start_move) begin
            eff_q    <= size_eff;
            nh_q     <= next_head;
            border_q <= border_hit;
            body_q   <= 1'b0;
            grow_q   <= count_size;
            idx      <= IW'(size_eff - SW'(1));
          end
        end
        S_INIT: begin
          seg[idx] <= {GRID_BITS'(START_X) - GRID_BITS'(idx), GRID_BITS'(START_Y)};
          idx      <= idx + IW'(1);
          if (state_next == S_DONE) size_q <= SW'(INIT_SIZE);
        end
        S_SHIFT: begin
          seg[idx] <= seg[idx - IW'(1)];
          idx      <= idx - IW'(1);
        end
        S_HEAD: begin
          seg[0] <= nh_q;
          size_q <= eff_q;
          idx    <= IW'(1);
        end
        S_CHECK: begin
          if (seg[idx] == seg[0]) body_q <= 1'b1;
          idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign head_pos     = seg[0];
  assign render_pos   = seg[render_idx];
  assign render_valid = (SW'(render_idx) < size_q);
  assign size         = size_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign is_at_border = border_q;
  assign is_at_body   = body_q;
  assign is_at_apple  = !busy_q && (seg[0] == apple_pos);

endmodule

// File: tb/tb_sga_snake_body.sv
// Self-checking bench for sga_snake_body against a queue-based snake model.
module tb_sga_snake_body;
  import sga_pkg::*;

  localparam int MS = 16;
  localparam int IS = 3;
  localparam int GN = 16;

  logic       clock = 1'b0;
  logic       restart_n = 1'b1;
  logic       clear_size = 1'b0;
  logic       load_size = 1'b0;
  logic       count_size = 1'b0;
  logic       move = 1'b0;
  logic [1:0] direction = 2'b00;
  pos_t       apple_pos = '0;
  logic [3:0] render_idx = '0;
  pos_t       render_pos;
  logic       render_valid;
  pos_t       head_pos;
  logic [4:0] size;
  logic       busy, done, is_at_apple, is_at_border, is_at_body;

  int errors = 0;
  int checks = 0;

  sga_snake_body dut (
    .clock(clock), .restart_n(restart_n), .clear_size(clear_size), .load_size(load_size),
    .count_size(count_size), .move(move), .direction(direction), .apple_pos(apple_pos),
    .render_idx(render_idx), .render_pos(render_pos), .render_valid(render_valid),
    .head_pos(head_pos), .size(size), .busy(busy), .done(done), .is_at_apple(is_at_apple),
    .is_at_border(is_at_border), .is_at_body(is_at_body)
  );

  always #5 clock = ~clock;

  // Reference model: mq[0] is the head, mq.size() the length.
  pos_t mq[$];
  bit   m_grow, m_border, m_body;

  function automatic pos_t mk(input int x, input int y);
    logic [3:0] xs, ys;
    xs = 4'(x);
    ys = 4'(y);
    return {xs, ys};
  endfunction

  function automatic void model_load();
    mq.delete();
    for (int i = 0; i < IS; i++) mq.push_back(mk(8 - i, 8));
    m_border = 0;
    m_body   = 0;
  endfunction

  function automatic int model_move(input logic [1:0] dir);
    int sz, eff, hx, hy, nx, ny;
    pos_t nh;
    pos_t nq[$];
    sz  = mq.size();
    eff = sz;
    if (m_grow) eff = (sz + 1 > MS) ? MS : sz + 1;
    if (eff < 1) eff = 1;
    m_grow = 0;
    hx = (sz > 0) ? int'(mq[0][7:4]) : 0;
    hy = (sz > 0) ? int'(mq[0][3:0]) : 0;
    nx = hx;
    ny = hy;
    case (dir)
      2'b00:   nx = hx + 1;
      2'b01:   ny = hy - 1;
      2'b10:   nx = hx - 1;
      default: ny = hy + 1;
    endcase
`ifdef SGA_WRAP_EN
    nx = (nx + GN) % GN;
    ny = (ny + GN) % GN;
`else
    if (nx < 0 || nx >= GN || ny < 0 || ny >= GN) begin
      m_border = 1;
      m_body   = 0;
      return 1;
    end
`endif
    m_border = 0;
    nh = mk(nx, ny);
    nq.push_back(nh);
    for (int i = 0; i < eff - 1; i++) nq.push_back(mq[i]);
    m_body = 0;
    for (int i = 1; i < nq.size(); i++) if (nq[i] == nh) m_body = 1;
    mq = nq;
    return 2 * eff;
  endfunction

  // Stimulus: pulse a command, then count edges until done (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic issue_move(input logic [1:0] d, output int lat);
    @(negedge clock); direction = d; move = 1'b1;
    @(negedge clock); move = 1'b0;
    wait_done(lat);
  endtask

  task automatic issue_load(output int lat);
    @(negedge clock); load_size = 1'b1;
    @(negedge clock); load_size = 1'b0;
    wait_done(lat);
  endtask

  task automatic pulse_count();
    @(negedge clock); count_size = 1'b1;
    @(negedge clock); count_size = 1'b0;
    m_grow = 1;
  endtask

  task automatic test_reset();
    apple_pos = mk(1, 1);
    #1;
    checks++; if (size !== 5'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", size); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    checks++; if (head_pos !== 8'h00) begin errors++; $display("FAIL reset_head: got %h expected 00", head_pos); end
    checks++; if ({is_at_border, is_at_body, is_at_apple, render_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {is_at_border, is_at_body, is_at_apple, render_valid}); end
  endtask

  task automatic test_load();
    int lat;
    model_load();
    issue_load(lat);
    checks++; if (lat !== IS + 1) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, IS + 1); end
    checks++; if (size !== 5'(IS)) begin errors++; $display("FAIL load_size: got %0d expected %0d", size, IS); end
    for (int i = 0; i < IS; i++) begin
      render_idx = 4'(i); #1;
      checks++; if (render_pos !== mk(8 - i, 8) || render_valid !== 1'b1) begin
        errors++; $display("FAIL load_seg%0d: got %h/%b expected %h/1", i, render_pos, render_valid, mk(8 - i, 8)); end
    end
  endtask

  task automatic test_move();
    int lat, exp;
    exp = model_move(2'b00);
    issue_move(2'b00, lat);
    checks++; if (lat !== 6 || exp !== 6) begin errors++; $display("FAIL move_latency: got %0d expected 6", lat); end
    checks++; if (head_pos !== mk(9, 8)) begin errors++; $display("FAIL move_head: got %h expected %h", head_pos, mk(9, 8)); end
    render_idx = 4'd2; #1;
    checks++; if (render_pos !== mk(7, 8)) begin errors++; $display("FAIL move_seg2: got %h expected %h", render_pos, mk(7, 8)); end
    checks++; if ({is_at_border, is_at_body, is_at_apple} !== 3'b000) begin
      errors++; $display("FAIL move_flags: got %b expected 000", {is_at_border, is_at_body, is_at_apple}); end
    apple_pos = mk(9, 8); #1;
    checks++; if (is_at_apple !== 1'b1) begin errors++; $display("FAIL move_apple: got %b expected 1", is_at_apple); end
  endtask

  task automatic test_grow_apple();
    int lat, exp;
    pulse_count();
    exp = model_move(2'b00);
    issue_move(2'b00, lat);
    checks++; if (lat !== exp) begin errors++; $display("FAIL grow_latency: got %0d expected %0d", lat, exp); end
    checks++; if (size !== 5'd4) begin errors++; $display("FAIL grow_size: got %0d expected 4", size); end
    checks++; if (head_pos !== mk(10, 8)) begin errors++; $display("FAIL grow_head: got %h expected %h", head_pos, mk(10, 8)); end
    apple_pos = mk(10, 8); #1;
    checks++; if (is_at_apple !== 1'b1) begin errors++; $display("FAIL grow_apple: got %b expected 1", is_at_apple); end
  endtask

  task automatic test_border();
    int lat, exp;
    for (int k = 0; k < 5; k++) begin
      exp = model_move(2'b00);
      issue_move(2'b00, lat);
      checks++; if (lat !== exp) begin errors++; $display("FAIL border_walk%0d: got %0d expected %0d", k, lat, exp); end
    end
    checks++; if (head_pos !== mk(15, 8)) begin errors++; $display("FAIL border_pre_head: got %h expected %h", head_pos, mk(15, 8)); end
    exp = model_move(2'b00);
    issue_move(2'b00, lat);
    checks++; if (lat !== exp || is_at_border !== m_border) begin
      errors++; $display("FAIL border_step: got lat %0d flag %b expected lat %0d flag %b", lat, is_at_border, exp, m_border); end
`ifdef SGA_WRAP_EN
    checks++; if (head_pos !== mk(0, 8) || is_at_border !== 1'b0) begin
      errors++; $display("FAIL border_wrap: got %h/%b expected %h/0", head_pos, is_at_border, mk(0, 8)); end
`else
    checks++; if (lat !== 1 || is_at_border !== 1'b1 || head_pos !== mk(15, 8)) begin
      errors++; $display("FAIL border_hit: got lat %0d flag %b head %h expected 1/1/%h", lat, is_at_border, head_pos, mk(15, 8)); end
`endif
    for (int i = 0; i < mq.size(); i++) begin
      render_idx = 4'(i); #1;
      checks++; if (render_pos !== mq[i]) begin errors++; $display("FAIL border_seg%0d: got %h expected %h", i, render_pos, mq[i]); end
    end
  endtask

  task automatic test_body();
    int lat, exp;
    logic [1:0] dirs [5] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b01};
    model_load();
    issue_load(lat);
    for (int k = 0; k < 5; k++) begin
      if (k < 2) pulse_count();
      exp = model_move(dirs[k]);
      issue_move(dirs[k], lat);
      checks++; if (lat !== exp || is_at_body !== m_body) begin
        errors++; $display("FAIL body_move%0d: got lat %0d body %b expected lat %0d body %b", k, lat, is_at_body, exp, m_body); end
    end
    checks++; if (size !== 5'd5 || is_at_body !== 1'b1) begin
      errors++; $display("FAIL body_final: got size %0d body %b expected 5/1", size, is_at_body); end
  endtask

  task automatic test_back_to_back();
    int lat, extra;
    model_load();
    @(negedge clock); load_size = 1'b1;
    @(negedge clock); load_size = 1'b0;
    move = 1'b1; clear_size = 1'b1; load_size = 1'b1; count_size = 1'b1;
    @(negedge clock); move = 1'b0; clear_size = 1'b0; load_size = 1'b0; count_size = 1'b0;
    m_grow = 1;
    wait_done(lat);
    checks++; if (lat >= 200) begin errors++; $display("FAIL busy_done_timeout: got %0d cycles expected done", lat); end
    extra = 0;
    for (int c = 0; c < 20; c++) begin @(posedge clock); #1; if (done || busy) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignored_cmd: got %0d active cycles expected 0", extra); end
    checks++; if (size !== 5'(IS) || head_pos !== mk(8, 8)) begin
      errors++; $display("FAIL busy_state: got size %0d head %h expected %0d/%h", size, head_pos, IS, mk(8, 8)); end
    lat = model_move(2'b01);
    issue_move(2'b01, extra);
    checks++; if (size !== 5'(mq.size()) || extra !== lat) begin
      errors++; $display("FAIL busy_count_kept: got size %0d lat %0d expected %0d/%0d", size, extra, mq.size(), lat); end
  endtask

  task automatic test_clear();
    int lat;
    @(negedge clock); clear_size = 1'b1; load_size = 1'b1; move = 1'b1;
    @(negedge clock); clear_size = 1'b0; load_size = 1'b0; move = 1'b0;
    render_idx = 4'd0; #1;
    checks++; if ({size, busy, render_valid} !== 7'd0) begin
      errors++; $display("FAIL clear: got size %0d busy %b valid %b expected 0/0/0", size, busy, render_valid); end
    model_load();
    issue_load(lat);
  endtask

  task automatic test_reset_abort();
    int seen;
    apple_pos = mk(3, 3);
    @(negedge clock); direction = 2'b11; move = 1'b1;
    @(negedge clock); move = 1'b0;
    #2 restart_n = 1'b0;
    #1;
    checks++; if ({size, busy, done, head_pos, render_pos, render_valid} !== '0 ||
                  {is_at_apple, is_at_border, is_at_body} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs: got size %0d busy %b done %b head %h pos %h", size, busy, done, head_pos, render_pos); end
    @(negedge clock); restart_n = 1'b1;
    mq.delete(); m_grow = 0; m_border = 0; m_body = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin @(posedge clock); #1; if (done) seen++; end
    checks++; if (seen !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_saturate();
    int lat, exp;
    logic [1:0] sq [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    model_load();
    issue_load(lat);
    for (int k = 0; k < 15; k++) begin
      pulse_count();
      exp = model_move(sq[k % 4]);
      issue_move(sq[k % 4], lat);
      checks++; if (lat !== exp || size !== 5'(mq.size())) begin
        errors++; $display("FAIL sat_move%0d: got lat %0d size %0d expected %0d/%0d", k, lat, size, exp, mq.size()); end
    end
    checks++; if (size !== 5'(MS)) begin errors++; $display("FAIL sat_size: got %0d expected %0d", size, MS); end
    for (int i = 0; i < MS; i++) begin
      render_idx = 4'(i); #1;
      checks++; if (render_pos !== mq[i]) begin errors++; $display("FAIL sat_seg%0d: got %h expected %h", i, render_pos, mq[i]); end
    end
  endtask

  task automatic test_random();
    int lat, exp;
    logic [1:0] d;
    model_load();
    issue_load(lat);
    for (int k = 0; k < 60; k++) begin
      apple_pos = pos_t'($urandom);
      if ($urandom_range(0, 1) == 1) pulse_count();
      d = 2'($urandom_range(0, 3));
      exp = model_move(d);
      issue_move(d, lat);
      checks++; if (lat !== exp || size !== 5'(mq.size()) || head_pos !== mq[0]) begin
        errors++; $display("FAIL rnd%0d_move: got lat %0d size %0d head %h expected %0d/%0d/%h", k, lat, size, head_pos, exp, mq.size(), mq[0]); end
      checks++; if ({is_at_border, is_at_body, is_at_apple} !== {m_border, m_body, mq[0] == apple_pos}) begin
        errors++; $display("FAIL rnd%0d_flags: got %b expected %b", k, {is_at_border, is_at_body, is_at_apple},
                           {m_border, m_body, mq[0] == apple_pos}); end
      for (int i = 0; i < mq.size(); i++) begin
        render_idx = 4'(i); #1;
        checks++; if (render_pos !== mq[i]) begin errors++; $display("FAIL rnd%0d_seg%0d: got %h expected %h", k, i, render_pos, mq[i]); end
      end
    end
  endtask

  initial begin
    #2 restart_n = 1'b0;
    repeat (2) @(negedge clock);
    restart_n = 1'b1;
    test_reset();
    test_load();
    test_move();
    test_grow_apple();
    test_border();
    test_body();
    test_back_to_back();
    test_clear();
    test_reset_abort();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sga_snake_body.md
SGA_SNAKE_BODY -- requirements
Module: sga_snake_body

Interface
REQ-001 Parameter GRID_BITS, default 4: bits per coordinate; the grid is 2^GRID_BITS x 2^GRID_BITS.
REQ-002 Parameter MAX_SIZE, default 16: maximum segment count.
REQ-003 Parameter INIT_SIZE, default 3: segment count after load.
REQ-004 Parameter START_X / START_Y, default 8 / 8: initial head cell.
REQ-005 Port list SHALL be, in this order (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge.
- restart_n  in  1  asynchronous active-low reset.
- clear_size  in  1  zero the size, level-sampled.
- load_size  in  1  start the initial-body load, pulse.
- count_size  in  1  arm growth for the next move, pulse.
- move  in  1  start one move step, pulse.
- direction  in  2  00 right (x+1), 01 up (y-1), 10 left (x-1), 11 down (y+1).
- apple_pos  in  2*GRID_BITS  {x,y} of the apple.
- render_idx  in  $clog2(MAX_SIZE)  segment read index.
- render_pos  out  2*GRID_BITS  segment[render_idx], combinational.
- render_valid  out  1  render_idx < size.
- head_pos  out  2*GRID_BITS  segment[0].
- size  out  $clog2(MAX_SIZE)+1  current length.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse ending a load or move.
- is_at_apple / is_at_border / is_at_body  out  1 each  status flags, valid while busy=0.

Function
REQ-006 FSM states SHALL be IDLE, INIT, SHIFT, HEAD, CHECK, DONE.
REQ-007 In IDLE, the command priority SHALL be clear_size > load_size > move; count_size is accepted in any state.
REQ-008 load_size SHALL cause INIT to write segment[i] = (START_X-i, START_Y) for i = 0..INIT_SIZE-1, one segment per cycle, then set size=INIT_SIZE, then enter DONE.
REQ-009 count_size SHALL set a grow flag; the next move uses size_eff = min(size+1, MAX_SIZE) and clears the flag.
REQ-010 On move, the next head SHALL be computed; if it is off-grid, then is_at_border<=1, no segment changes, and the FSM goes straight to DONE (done one cycle later).
REQ-011 Otherwise the FSM SHALL step through:
- SHIFT: size_eff-1 cycles, segment[i]<=segment[i-1] for i from size_eff-1 down to 1.
- HEAD: segment[0]<=next head, size<=size_eff.
- CHECK: size_eff-1 cycles comparing the head against segments 1..size_eff-1; set is_at_body on any match.
- DONE.
REQ-012 done SHALL assert exactly 2*size_eff cycles after the edge that samples move; SHIFT and CHECK are skipped when size_eff=1.
REQ-013 is_at_border and is_at_body SHALL clear when a new move or load is accepted.
REQ-014 is_at_apple SHALL be combinational: head_pos == apple_pos, forced to 0 while busy.
REQ-015 move, load_size, or clear_size asserted while busy SHALL be ignored.
REQ-016 When size=MAX_SIZE with the grow flag set, size SHALL saturate and the tail SHALL drop.
REQ-017 Coordinate arithmetic SHALL be unsigned GRID_BITS wide; the border test uses the carry/borrow out of x±1 and y±1.

Reset
REQ-018 restart_n low SHALL asynchronously force: state IDLE, size 0, grow flag 0, all segments 0, done/busy/flags 0.
REQ-019 Reset asserted mid-INIT or mid-move SHALL abort the operation, with no done pulse.

Configuration
REQ-020 Macro SGA_WRAP_EN: when defined, next-head coordinates SHALL wrap modulo 2^GRID_BITS and is_at_border stays 0; when undefined, REQ-010 applies.

Structure
REQ-021 Package sga_pkg SHALL hold:
- direction encoding constants.
- position type (2*GRID_BITS).
- default GRID_BITS, MAX_SIZE, INIT_SIZE, START_X, START_Y.
REQ-022 Sub-module sga_next_head SHALL hold the combinational logic (head, direction) -> (next head, border_hit), including the SGA_WRAP_EN variant.

Verification
REQ-023 Reset then load_size -> done after 3 INIT cycles + DONE; size=3; segments (8,8),(7,8),(6,8).
REQ-024 move with direction=00 -> done 6 cycles after sampling; head=(9,8); segment[2]=(7,8); all flags 0.
REQ-025 apple_pos=(9,8), count_size, then move with direction=00 -> size=4; head=(10,8) after that move; is_at_apple=1 when apple_pos=(10,8).
REQ-026 Head at (15,8), move with direction=00 -> is_at_border=1, done 1 cycle later, segments unchanged; with SGA_WRAP_EN: head=(0,8), is_at_border=0.
REQ-027 Size 5, moves down, left, up (directions 11, 10, 01) -> the last move sets is_at_body=1.
REQ-028 restart_n pulsed low during SHIFT -> all outputs 0 immediately; no done pulse; a move issued while busy is ignored.
